// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM states and instruction-field constants.
// StHalt exists only when FETCH_ALIGN_CHECK_EN is defined.
package mips_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    StHalt  = 3'd5
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_PC, load has priority over increment.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc;
    end else if (inc) begin
      pc_q <= pc_q + PC_INC;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding imem requests, hands
// instructions to decode. Optional FETCH_ALIGN_CHECK_EN halts fetch on a misaligned redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc;
  logic [31:0] target_pc;
  logic        pc_load;
  logic        pc_inc;
  logic        capture;
  logic        halted;
  logic        misaligned;

  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] pc_plus4_q;
  logic        instr_valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign halted     = (state_q == StHalt);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign misaligned          = 1'b0;
  assign halted              = 1'b0;
`endif

  // Low bits are dropped so the PC can never become misaligned.
  assign target_pc = {redirect_pc[31:2], 2'b00};

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pc_load),
    .load_pc(target_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = StWait;
      StWait: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_valid_q && instr_ready) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (imem_rvalid) begin
          state_d = StFetch;
        end
      end
      default: state_d = state_q;
    endcase

    // Redirect overrides everything; a response arriving in the same cycle is the stale one,
    // so it is dropped and no drain is needed.
    if (redirect_valid && !halted && !misaligned) begin
      capture = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b1;
      unique case (state_q)
        StWait, StDrain: state_d = imem_rvalid ? StFetch : StDrain;
        default:         state_d = StFetch;
      endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect_valid && !halted && misaligned) begin
      capture = 1'b0;
      pc_inc  = 1'b0;
      state_d = StHalt;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      instr_q       <= NOP;
      instr_pc_q    <= 32'h0000_0000;
      pc_plus4_q    <= PC_INC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= (state_d == StHold);
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
        pc_plus4_q <= pc + PC_INC;
      end
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign instr_valid = instr_valid_q;

  // Sticky by construction: only reset leaves StHalt.
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misalign = halted;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule
